// File: rtl/rc4_pkg.sv
// rc4_pkg: shared RC4 types and sizes for the key-schedule and decrypt stages.
// Contents: ksa_state_t state enum (INIT_WR present only with INIT_FILL_EN),
// MEM_DEPTH (S-memory bytes), KEY_BYTES (secret key length), key_byte() helper.
package rc4_pkg;
    localparam int MEM_DEPTH = 256;
    localparam int KEY_BYTES = 3;

    typedef enum logic [3:0] {
        IDLE,
`ifdef INIT_FILL_EN
        INIT_WR,
`endif
        RD_I,
        WAIT_I,
        CALC_J,
        RD_J,
        WAIT_J,
        WR_I,
        WR_J,
        INC_I,
        DONE
    } ksa_state_t;

    // byte 0 is the most significant byte of the key
    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] k);
        return k == 2'd0 ? key[23:16] : k == 2'd1 ? key[15:8] : key[7:0];
    endfunction
endpackage

// File: rtl/ksa_shuffle_if.sv
// ksa_shuffle_if: control handshake and S-memory bus of the RC4 key scheduler.
// Signals: start/secret_key (request), finish (done), ksa_mem_handler (bus owned),
// address/data/wen (memory write port), q_data (memory read data, latency 2).
// master = key scheduler side, slave = memory/controller side.
interface ksa_shuffle_if;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q_data;
    logic        finish;
    logic        ksa_mem_handler;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wen;

    modport master (
        input  start, secret_key, q_data,
        output finish, ksa_mem_handler, address, data, wen
    );
    modport slave (
        output start, secret_key, q_data,
        input  finish, ksa_mem_handler, address, data, wen
    );
endinterface

// File: rtl/ksa_shuffle.sv
// ksa_shuffle: RC4 key-scheduling shuffle over an external 256-byte S-memory.
// Ports: clk (rising edge), reset_n (async active-low), bus (ksa_shuffle_if.master).
// Optional INIT_FILL_EN: adds INIT_WR, which fills S[n]=n before the shuffle;
// without it S must already hold the identity permutation.
module ksa_shuffle
    import rc4_pkg::*;
(
    input logic clk,
    input logic reset_n,
    ksa_shuffle_if.master bus
);
    ksa_state_t state, state_n;
    logic [7:0] i, j, si;
    logic [1:0] kidx;
    logic [7:0] address, data;
    logic       wen, finish;

    assign bus.address         = address;
    assign bus.data            = data;
    assign bus.wen             = wen;
    assign bus.finish          = finish;
    assign bus.ksa_mem_handler = state != IDLE;

    always_comb begin
        state_n = state;
        address = 8'd0;
        data    = 8'd0;
        wen     = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
`ifdef INIT_FILL_EN
                if (bus.start) state_n = INIT_WR;
`else
                if (bus.start) state_n = RD_I;
`endif
            end
`ifdef INIT_FILL_EN
            INIT_WR: begin
                address = i;
                data    = i;
                wen     = 1'b1;
                if (i == 8'(MEM_DEPTH - 1)) state_n = RD_I;
            end
`endif
            RD_I: begin
                address = i;
                state_n = WAIT_I;
            end
            WAIT_I: begin
                address = i;
                state_n = CALC_J;
            end
            CALC_J: begin
                address = i;
                state_n = RD_J;
            end
            RD_J: begin
                address = j;
                state_n = WAIT_J;
            end
            WAIT_J: begin
                address = j;
                state_n = WR_I;
            end
            // q_data still carries S[j]; when i==j both writes store si at one address
            WR_I: begin
                address = i;
                data    = bus.q_data;
                wen     = 1'b1;
                state_n = WR_J;
            end
            WR_J: begin
                address = j;
                data    = si;
                wen     = 1'b1;
                state_n = INC_I;
            end
            INC_I: state_n = i == 8'(MEM_DEPTH - 1) ? DONE : RD_I;
            DONE: begin
                finish = 1'b1;
                if (!bus.start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            kidx  <= 2'd0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (bus.start) begin
                    i    <= 8'd0;
                    j    <= 8'd0;
                    kidx <= 2'd0;
                end
`ifdef INIT_FILL_EN
                INIT_WR: i <= i + 8'd1;
`endif
                CALC_J: begin
                    si <= bus.q_data;
                    j  <= j + bus.q_data + key_byte(bus.secret_key, kidx);
                end
                INC_I: begin
                    if (i != 8'(MEM_DEPTH - 1)) i <= i + 8'd1;
                    kidx <= kidx == 2'(KEY_BYTES - 1) ? 2'd0 : kidx + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
